ula_control_md: RTL
===================

# ula_control_md

Parametrised successor to the ALU control decoder. It keeps the combinational `ula_operation`/`func` → `operation` mapping and adds an iterative multiply/divide unit with HI/LO registers. A `stall` handshake holds the pipeline while a multi-cycle operation is in flight. It sits between the main control unit and the ALU/register-file write-back mux in the EX stage.

## Interface

Parameters:
- `WIDTH`, 32, operand and HI/LO width (≥ 4, power of two not required).
- `CNT_W`, `$clog2(WIDTH+1)`, iteration counter width (derived; do not override).

Ports (one clock; reset is asynchronous, active-low):
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `valid` in 1: the EX-stage instruction is real (not a bubble).
- `ula_operation` in 4: ALU op class from main control.
- `func` in 6: R-type function field.
- `a` in WIDTH: rs operand.
- `b` in WIDTH: rt operand.
- `operation` out 4: ALU operation code (combinational).
- `hi`, `lo` out WIDTH: HI/LO registers.
- `busy` out 1: mul/div iteration in progress.
- `done` out 1: one-cycle pulse; HI/LO hold the new result.
- `stall` out 1: freeze the upstream pipeline this cycle (combinational).

## Operation

- **Decode**
  - Mapping is unchanged for all existing classes: 0000→0010, 0001→0110, 0011→0111, 1000→1000, 0100→0000, 0101→0001, 0110→1101, 0111→1011, default→0000.
  - R-type funcs are unchanged: add 0010, sub 0110, and 0000, or 0001, xor 1101, nor 1100, slt/sltu 0111, sll 0011, srl 0101, sra 0100, sllv 1110, srlv 1111, srav 1010, default 0000.
- **New R-type funcs**
  - mult 011000, multu 011001, div 011010, divu 011011: `operation`=0010 (ALU result unused).
  - mfhi 010000, mthi 010001, mflo 010010, mtlo 010011: `operation`=1001 (pass-through; write-back mux selects hi/lo).
- **Request**: `req_md` = `valid` && `ula_operation`==0010 && func ∈ {mult, multu, div, divu}. `req_hl` = same condition for the mfhi/mthi/mflo/mtlo funcs.
- **`stall`** = (`req_md` || `req_hl`) && `busy`.
- **FSM**: IDLE, MUL, DIV, DONE.
  - IDLE, `req_md` mult/multu → MUL. Latch |a| and |b| (signed magnitudes for mult, raw for multu), the result sign, and counter=WIDTH.
  - IDLE, `req_md` div/divu → DIV with the same latching. If `b`==0 → DONE directly.
  - MUL: shift-add, 2·WIDTH-bit accumulator, one bit per cycle. Counter hits 0 → DONE.
  - DIV: restoring divide, one quotient bit per cycle. Counter hits 0 → DONE.
  - DONE: always → IDLE. A `req_md` in DONE is accepted on the next cycle (IDLE), not in DONE.
- **Result, written into HI/LO on the edge entering DONE**
  - Mult: {hi,lo} = product, two's-complement negated if the sign is set.
  - Div: lo = quotient, hi = remainder. Quotient is negated if the operand signs differ. Remainder takes the dividend's sign.
  - Divide by zero: hi=`a`, lo=all ones.
- **mthi/mtlo**: write `a` into hi/lo on the edge when `req_hl` && !`busy`.
- **mfhi/mflo**: no state change.
- **Overflow**: signed div of most-negative/−1 gives lo=most-negative, hi=0. The wrap is defined, with no trap.

## Timing

- Reset state: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. `stall` is 0 (busy=0).
- `busy` = state ∈ {MUL, DIV}. `done` = state==DONE. Both are registered-state outputs.
- Latency, accept edge to `done`=1:
  - mult/div: WIDTH+1 cycles.
  - Divide by zero: 1 cycle.
- HI/LO are valid in the `done` cycle. An mfhi issued in the `done` cycle sees the new value without a stall.
- Requests while busy: a second `req_md` is not accepted; it is held by `stall` and accepted when the FSM returns to IDLE. mthi/mtlo while busy stall the same way; they never corrupt an in-flight result.
- `valid`=0 never starts an operation or stalls.
- Reset mid-operation: `rst_n` low aborts immediately. The in-flight result is discarded and HI/LO read 0.

## Configuration

- `ULA_DIV_EN` defined: div/divu are decoded and executed as above.
- `ULA_DIV_EN` undefined:
  - The DIV state and divider datapath are not compiled.
  - div/divu decode `operation`=0000, never assert `req_md`, never stall, and leave HI/LO unchanged.
  - mult/multu and HI/LO moves are unaffected.

## Test plan

- Reset, then mult a=0xFFFFFFFD (−3), b=7 → `done` 33 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFEB; `busy` high for exactly 32 cycles.
- multu a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE.
- div a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div a=0x12345678, b=0 → `done` next cycle; hi=0x12345678, lo=0xFFFFFFFF.
- mfhi issued 5 cycles after a mult accept → `stall`=1 until the `done` cycle; hi is read correct with `stall`=0.
- mtlo a=0xA5A5A5A5 while idle → lo=0xA5A5A5A5. Start a mult, pull `rst_n` low at cycle 10 → hi=lo=0, busy=0, done=0. With `ULA_DIV_EN` off, div gives `operation`=0000, no stall, and HI/LO unchanged.

Source files
------------

// File: rtl/ula_control_md_if.sv
// EX-stage bundle between main control, ula_control_md and the write-back mux.
// The master drives the instruction fields; the slave returns the decode, HI/LO and handshake.
interface ula_control_md_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid;
    logic [3:0]       ula_operation;
    logic [5:0]       func;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       operation;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output valid, ula_operation, func, a, b,
        input  operation, hi, lo, busy, done, stall
    );

    modport slave (
        input  valid, ula_operation, func, a, b,
        output operation, hi, lo, busy, done, stall
    );
endinterface

// File: rtl/ula_control_md.sv
// ALU control decoder with an iterative multiply/divide unit and HI/LO registers.
// Define ULA_DIV_EN to build the restoring divider (div/divu); otherwise only mult/multu run.
module ula_control_md #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input logic             clk,
    input logic             rst_n,
    ula_control_md_if.slave bus
);
    localparam logic [5:0] FnMult  = 6'b011000;
    localparam logic [5:0] FnMultu = 6'b011001;
    localparam logic [5:0] FnMfhi  = 6'b010000;
    localparam logic [5:0] FnMthi  = 6'b010001;
    localparam logic [5:0] FnMflo  = 6'b010010;
    localparam logic [5:0] FnMtlo  = 6'b010011;
`ifdef ULA_DIV_EN
    localparam logic [5:0] FnDiv   = 6'b011010;
    localparam logic [5:0] FnDivu  = 6'b011011;
`endif

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
`ifdef ULA_DIV_EN
        StDiv  = 2'd2,
`endif
        StDone = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               sign_q, sign_d;

    logic [3:0]         op;
    logic               is_md, is_hl, req_md, req_hl, busy, fn_signed;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc, mul_res;

    always_comb begin
        op    = 4'b0000;
        is_md = 1'b0;
        is_hl = 1'b0;
        case (bus.ula_operation)
            4'b0000: op = 4'b0010;
            4'b0001: op = 4'b0110;
            4'b0011: op = 4'b0111;
            4'b1000: op = 4'b1000;
            4'b0100: op = 4'b0000;
            4'b0101: op = 4'b0001;
            4'b0110: op = 4'b1101;
            4'b0111: op = 4'b1011;
            4'b0010: begin
                case (bus.func)
                    6'b100000: op = 4'b0010;
                    6'b100010: op = 4'b0110;
                    6'b100100: op = 4'b0000;
                    6'b100101: op = 4'b0001;
                    6'b100110: op = 4'b1101;
                    6'b100111: op = 4'b1100;
                    6'b101010, 6'b101011: op = 4'b0111;
                    6'b000000: op = 4'b0011;
                    6'b000010: op = 4'b0101;
                    6'b000011: op = 4'b0100;
                    6'b000100: op = 4'b1110;
                    6'b000110: op = 4'b1111;
                    6'b000111: op = 4'b1010;
`ifdef ULA_DIV_EN
                    FnMult, FnMultu, FnDiv, FnDivu: begin
`else
                    FnMult, FnMultu: begin
`endif
                        op    = 4'b0010;
                        is_md = 1'b1;
                    end
                    FnMfhi, FnMthi, FnMflo, FnMtlo: begin
                        op    = 4'b1001;
                        is_hl = 1'b1;
                    end
                    default: op = 4'b0000;
                endcase
            end
            default: op = 4'b0000;
        endcase
    end

    assign req_md    = bus.valid & is_md;
    assign req_hl    = bus.valid & is_hl;
    assign fn_signed = ~bus.func[0];
    assign mag_a     = (fn_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mag_b     = (fn_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Shift-add: multiplier sits in the low half and is consumed one bit per cycle.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    assign mul_acc = {mul_sum, acc_q[WIDTH-1:1]};
    assign mul_res = sign_q ? -mul_acc : mul_acc;

`ifdef ULA_DIV_EN
    logic               rsign_q, rsign_d;
    logic [WIDTH:0]     rem_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff, rem_nx, quo, rem;
    logic [2*WIDTH-1:0] div_acc;

    // Restoring divide: {remainder, dividend} shifts left, quotient bits enter at the bottom.
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge   = rem_sh >= {1'b0, dvs_q};
    assign div_diff = rem_sh[WIDTH-1:0] - dvs_q;
    assign rem_nx   = div_ge ? div_diff : rem_sh[WIDTH-1:0];
    assign div_acc  = {rem_nx, acc_q[WIDTH-2:0], div_ge};
    assign quo      = div_acc[WIDTH-1:0];
    assign rem      = div_acc[2*WIDTH-1:WIDTH];
    assign busy     = (state_q == StMul) || (state_q == StDiv);
`else
    assign busy     = (state_q == StMul);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        sign_d  = sign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef ULA_DIV_EN
        rsign_d = rsign_q;
`endif
        if (req_hl && !busy && bus.func == FnMthi) hi_d = bus.a;
        if (req_hl && !busy && bus.func == FnMtlo) lo_d = bus.a;
        unique case (state_q)
            StIdle: begin
                if (req_md) begin
                    acc_d   = {{WIDTH{1'b0}}, mag_a};
                    dvs_d   = mag_b;
                    sign_d  = fn_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = StMul;
`ifdef ULA_DIV_EN
                    if (bus.func[1]) begin
                        rsign_d = fn_signed & bus.a[WIDTH-1];
                        state_d = StDiv;
                        if (bus.b == '0) begin
                            cnt_d   = '0;
                            hi_d    = bus.a;
                            lo_d    = '1;
                            state_d = StDone;
                        end
                    end
`endif
                end
            end
            StMul: begin
                acc_d = mul_acc;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    {hi_d, lo_d} = mul_res;
                    state_d      = StDone;
                end
            end
`ifdef ULA_DIV_EN
            StDiv: begin
                acc_d = div_acc;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    lo_d    = sign_q ? -quo : quo;
                    hi_d    = rsign_q ? -rem : rem;
                    state_d = StDone;
                end
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            sign_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            sign_q  <= sign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

`ifdef ULA_DIV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rsign_q <= 1'b0;
        else        rsign_q <= rsign_d;
    end
`endif

    assign bus.operation = op;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.busy      = busy;
    assign bus.done      = (state_q == StDone);
    assign bus.stall     = (req_md | req_hl) & busy;
endmodule
